// File: rtl/lc3b_types.sv
// Shared LC-3b types and constants. The branch predictor uses the word type
// and the saturating-counter encoding defined here.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_bp_ctr;

    localparam lc3b_bp_ctr BP_STRONG_NT = 2'b00;
    localparam lc3b_bp_ctr BP_WEAK_NT   = 2'b01;
    localparam lc3b_bp_ctr BP_WEAK_T    = 2'b10;
    localparam lc3b_bp_ctr BP_STRONG_T  = 2'b11;

endpackage

// File: rtl/bp_sat_counter2.sv
// Next-state logic for a 2-bit saturating taken/not-taken counter.
// Taken moves the counter toward strong-taken; not-taken moves it toward strong-not-taken.
module bp_sat_counter2
    import lc3b_types::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != BP_STRONG_T) ctr_o = ctr_i + 2'b01;
        end else begin
            if (ctr_i != BP_STRONG_NT) ctr_o = ctr_i - 2'b01;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters for LC-3b fetch, updated from WB,
// plus saturating branch and mispredict performance counters.
module branch_predictor
    import lc3b_types::*;
#(
    parameter int INDEX_BITS = 3
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] fetch_pc,
    output logic        predict_taken,
    output logic [15:0] predict_target,
    input  logic        wb_branch,
    input  logic [15:0] wb_pc,
    input  logic        wb_taken,
    input  logic [15:0] wb_target,
    input  logic        wb_mispredict,
    input  logic        bp_clear,
    output logic [15:0] branch_count,
    output logic [15:0] mispredict_count
);

    localparam int TAG_BITS = 15 - INDEX_BITS;
    localparam int ENTRIES  = 1 << INDEX_BITS;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    lc3b_word            target_q [ENTRIES];
    lc3b_bp_ctr          ctr_q    [ENTRIES];

    logic                valid_d  [ENTRIES];
    logic [TAG_BITS-1:0] tag_d    [ENTRIES];
    lc3b_word            target_d [ENTRIES];
    lc3b_bp_ctr          ctr_d    [ENTRIES];

    lc3b_word branch_q, branch_d;
    lc3b_word mispredict_q, mispredict_d;

    logic [INDEX_BITS-1:0] fetchIdx, wbIdx;
    logic [TAG_BITS-1:0]   fetchTag, wbTag;
    logic                  fetchHit, wbHit;
    lc3b_bp_ctr            ctrNext;
    logic                  unusedPcLsb;

    assign fetchIdx = fetch_pc[INDEX_BITS:1];
    assign fetchTag = fetch_pc[15:INDEX_BITS+1];
    assign wbIdx    = wb_pc[INDEX_BITS:1];
    assign wbTag    = wb_pc[15:INDEX_BITS+1];
    assign unusedPcLsb = fetch_pc[0] ^ wb_pc[0];

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    assign fetchHit       = valid_q[fetchIdx] && (tag_q[fetchIdx] == fetchTag);
    assign predict_taken  = fetchHit && ctr_q[fetchIdx][1];
    assign predict_target = fetchHit ? target_q[fetchIdx] : 16'h0000;

    assign wbHit = valid_q[wbIdx] && (tag_q[wbIdx] == wbTag);

    bp_sat_counter2 u_ctr (
        .ctr_i   (ctr_q[wbIdx]),
        .taken_i (wb_taken),
        .ctr_o   (ctrNext)
    );

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            valid_d[i]  = valid_q[i];
            tag_d[i]    = tag_q[i];
            target_d[i] = target_q[i];
            ctr_d[i]    = ctr_q[i];
        end
        // A clear in the same cycle as a WB update discards the update.
        if (bp_clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_d[i] = 1'b0;
                ctr_d[i]   = BP_WEAK_NT;
            end
        end else if (wb_branch) begin
            if (wbHit) begin
                ctr_d[wbIdx] = ctrNext;
                if (wb_taken) target_d[wbIdx] = wb_target;
            end else if (wb_taken) begin
                valid_d[wbIdx]  = 1'b1;
                tag_d[wbIdx]    = wbTag;
                target_d[wbIdx] = wb_target;
                ctr_d[wbIdx]    = BP_WEAK_T;
            end
        end
    end

    always_comb begin
        branch_d     = branch_q;
        mispredict_d = mispredict_q;
        if (wb_branch && (branch_q != 16'hFFFF)) branch_d = branch_q + 16'h0001;
        if (wb_branch && wb_mispredict && (mispredict_q != 16'hFFFF))
            mispredict_d = mispredict_q + 16'h0001;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= BP_WEAK_NT;
            end
            branch_q     <= '0;
            mispredict_q <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= valid_d[i];
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                ctr_q[i]    <= ctr_d[i];
            end
            branch_q     <= branch_d;
            mispredict_q <= mispredict_d;
        end
    end

    assign branch_count     = branch_q;
    assign mispredict_count = mispredict_q;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch target buffer with a 2-bit saturating taken/not-taken counter per entry, for the LC-3b pipeline.
- Fetch stage looks up the current PC combinationally and receives `predict_taken` / `predict_target`. The PC mux uses these, and they travel down the pipe to WB as `predict_taken_wb` / `taken_pc_wb`.
- WB resolves each branch and writes the outcome back here.
- Also keeps branch and mispredict performance counters.

Parameters:
- INDEX_BITS, 3, log2 of entry count (8 entries); index = pc[INDEX_BITS:1].
- TAG_BITS, 15-INDEX_BITS, tag = pc[15:INDEX_BITS+1]; derived, not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- fetch_pc  in  16  PC being fetched
- predict_taken  out  1  hit and counter[1]==1
- predict_target  out  16  stored target on hit, else 16'h0000
- wb_branch  in  1  a resolved control-flow instruction is in WB this cycle
- wb_pc  in  16  PC of that instruction
- wb_taken  in  1  actual outcome
- wb_target  in  16  actual target (valid when wb_taken)
- wb_mispredict  in  1  flush unit asserted flush for this instruction
- bp_clear  in  1  synchronous invalidate of all entries
- branch_count  out  16  resolved branches, saturating
- mispredict_count  out  16  mispredictions, saturating

Behaviour:
- Entry state: valid, tag[TAG_BITS], target[16], ctr[2]. Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset (async, rst=1):
  - all valid=0, all ctr=01, tags and targets 0.
  - branch_count = mispredict_count = 0.
  - Outputs therefore predict_taken=0, predict_target=0.
- Lookup (combinational, zero latency):
  - hit = valid[idx] and tag[idx]==fetch_pc[15:INDEX_BITS+1].
  - predict_taken = hit & ctr[1]; predict_target = hit ? target : 0.
- Update (on posedge clk when wb_branch=1, rst=0, bp_clear=0):
  - Hit at wb_pc and wb_taken=1: ctr saturating increment (11 stays 11); target <= wb_target.
  - Hit at wb_pc and wb_taken=0: ctr saturating decrement (00 stays 00); target unchanged.
  - Miss and wb_taken=1: allocate/replace. valid<=1, tag<=wb_pc tag, target<=wb_target, ctr<=10.
  - Miss and wb_taken=0: no change; not-taken branches are never allocated.
- Perf counters (posedge clk):
  - branch_count += 1 when wb_branch.
  - mispredict_count += 1 when wb_branch & wb_mispredict.
  - Both hold at 16'hFFFF.
  - wb_mispredict with wb_branch=0 is ignored.
  - Perf counters are not affected by bp_clear.
- bp_clear:
  - Next edge clears all valid bits and sets all ctr to 01.
  - If wb_branch is asserted the same cycle, the table update is dropped; bp_clear wins. Perf counters still count.
- Same-cycle lookup and update to the same index: lookup returns pre-update state (no bypass). The new state is visible from the next cycle.
- Aliasing: two PCs with the same index and different tags replace each other. This only happens on a taken miss.
- Reset asserted mid-operation: all state returns to reset values immediately, independent of clk.
- No handshakes. wb_branch is a single-cycle pulse per retired branch; a stalled WB must deassert it after the first cycle.

Decomposition:
- Add to lc3b_types:
  - typedef lc3b_bp_ctr (logic [1:0]).
  - constants BP_STRONG_NT=2'b00, BP_WEAK_NT=2'b01, BP_WEAK_T=2'b10, BP_STRONG_T=2'b11.
  - reuse lc3b_word for PCs and targets.
- One natural sub-module, bp_sat_counter2:
  - combinational next-state of a 2-bit saturating counter from (ctr, taken).
  - instantiated once on the update path.
- Table arrays live in branch_predictor itself.

Test Plan:
- Reset then fetch_pc=16'h0040 -> predict_taken=0, predict_target=0, both perf counters 0.
- WB taken branch wb_pc=16'h0040, wb_target=16'h0100, then fetch_pc=16'h0040 -> predict_taken=1, predict_target=16'h0100; entry ctr=10. Fetch 16'h0050 (same index, different tag) -> predict_taken=0.
- Three taken updates at 16'h0040, then two not-taken -> ctr walks 10→11→11→10→01; predict_taken=0 after the second not-taken. Two further not-taken -> ctr 00, stays 00.
- Not-taken WB at a missing PC 16'h0060 -> no allocation; predict_taken=0, predict_target=0 at fetch 16'h0060.
- Same cycle: wb_branch taken at 16'h0040 and bp_clear=1 -> next cycle lookup at 16'h0040 misses; branch_count incremented by 1.
- Hold wb_branch=wb_mispredict=1 for 65540 cycles -> both counters read 16'hFFFF. Pulse rst mid-run without a clock edge -> counters 0 immediately.
